// File: rtl/mem_port_arbiter2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter2_pkg
// Purpose  : Shared definitions for the two-master memory port arbiter:
//            FSM state encoding, master index constants and the width of
//            the per-transaction timeout counter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_port_arbiter2_pkg;

    // Arbiter FSM states; encoding is fixed so it can be probed externally.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY0 = 2'b01,
        ST_BUSY1 = 2'b10
    } arb_state_e;

    // Master indices, also the value driven on the steering select.
    localparam logic c_M0 = 1'b0;
    localparam logic c_M1 = 1'b1;

    // Width of the per-transaction timeout counter (timeout up to 255).
    localparam int c_TCNT_W = 8;

endpackage : mem_port_arbiter2_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter2_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick2
// Purpose  : Combinational two-way round-robin winner selection.
// Ports    : req0_i   - request from master 0
//            req1_i   - request from master 1
//            last_i   - master granted most recently
//            valid_o  - at least one request is present
//            winner_o - index of the master to grant (meaningful if valid_o)
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick2
    import mem_port_arbiter2_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic valid_o,
    output logic winner_o
);

    always_comb begin
        valid_o  = req0_i | req1_i;
        winner_o = c_M0;
        if (req0_i && req1_i) begin
            // Tie: the master that was not served last goes first.
            winner_o = ~last_i;
        end else if (req1_i) begin
            winner_o = c_M1;
        end
    end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/mux2.sv
`default_nettype none
// ============================================================================
// Module   : mux2
// Purpose  : Generic 2:1 datapath multiplexer used for memory port steering.
// Ports    : in0_i      - data selected when choose_bit = 0
//            in1_i      - data selected when choose_bit = 1
//            choose_bit - select
//            out_o      - selected data
// Revision : 1.0 - initial release
// ============================================================================
module mux2 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] in0_i,
    input  logic [WIDTH-1:0] in1_i,
    input  logic             choose_bit,
    output logic [WIDTH-1:0] out_o
);

    assign out_o = choose_bit ? in1_i : in0_i;

endmodule : mux2
`default_nettype wire

// File: rtl/mem_port_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter2
// Purpose  : Round-robin arbiter sharing one single-port memory between an
//            instruction-fetch master (M0) and a load/store master (M1).
//            Request/grant/done handshake with a per-transaction timeout;
//            steers address, write data and write enable through mux2.
// Ports    : clk, rst                 - clock, async active-high reset
//            m0_* / m1_*              - master request side (req, we, addr,
//                                       wdata in; gnt, done, err out)
//            rdata                    - read data, valid on done without err
//            sel                      - registered steering select
//            mem_en/we/addr/wdata     - memory access side outputs
//            mem_rdata, mem_ready     - memory response inputs
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter2
    import mem_port_arbiter2_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_done,
    output logic                  m0_err,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_done,
    output logic                  m1_err,

    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  sel,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
);

    // Counter value of the last BUSY cycle before the access is aborted.
    localparam logic [c_TCNT_W-1:0] c_TCNT_LAST = c_TCNT_W'(TIMEOUT - 1);

    arb_state_e            state_q, state_d;
    logic                  last_q, last_d;
    logic                  sel_q, sel_d;
    logic [c_TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic                  m0_gnt_q, m0_gnt_d;
    logic                  m1_gnt_q, m1_gnt_d;

    logic                  w_pick_valid;
    logic                  w_pick;
    logic                  w_timeout_hit;
    logic                  w_we_steer;

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
    rr_pick2 u_rr_pick2 (
        .req0_i   (m0_req),
        .req1_i   (m1_req),
        .last_i   (last_q),
        .valid_o  (w_pick_valid),
        .winner_o (w_pick)
    );

    assign w_timeout_hit = (tcnt_q == c_TCNT_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            last_q   <= c_M1;       // makes M0 win the first tie
            sel_q    <= c_M0;
            tcnt_q   <= '0;
            m0_gnt_q <= 1'b0;
            m1_gnt_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            sel_q    <= sel_d;
            tcnt_q   <= tcnt_d;
            m0_gnt_q <= m0_gnt_d;
            m1_gnt_q <= m1_gnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and completion logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        sel_d    = sel_q;
        tcnt_d   = tcnt_q;
        m0_gnt_d = 1'b0;
        m1_gnt_d = 1'b0;
        m0_done  = 1'b0;
        m0_err   = 1'b0;
        m1_done  = 1'b0;
        m1_err   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // mem_ready is deliberately not looked at here.
                if (w_pick_valid) begin
                    state_d = (w_pick == c_M1) ? ST_BUSY1 : ST_BUSY0;
                    sel_d   = w_pick;
                    last_d  = w_pick;
                    tcnt_d  = '0;
                    if (w_pick == c_M1) begin
                        m1_gnt_d = 1'b1;
                    end else begin
                        m0_gnt_d = 1'b1;
                    end
                end
            end

            ST_BUSY0: begin
                // The request line is not consulted: a granted access always
                // runs to completion or timeout. Returning to IDLE (never
                // directly to another BUSY) gives the bubble cycle that keeps
                // a stale request from being re-granted.
                tcnt_d = tcnt_q + 1'b1;
                if (mem_ready) begin
                    m0_done = 1'b1;
                    state_d = ST_IDLE;
                end else if (w_timeout_hit) begin
                    m0_done = 1'b1;
                    m0_err  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            ST_BUSY1: begin
                tcnt_d = tcnt_q + 1'b1;
                if (mem_ready) begin
                    m1_done = 1'b1;
                    state_d = ST_IDLE;
                end else if (w_timeout_hit) begin
                    m1_done = 1'b1;
                    m1_err  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath steering
    // ------------------------------------------------------------------
    mux2 #(.WIDTH(ADDR_WIDTH)) u_mux_addr (
        .in0_i      (m0_addr),
        .in1_i      (m1_addr),
        .choose_bit (sel_q),
        .out_o      (mem_addr)
    );

    mux2 #(.WIDTH(DATA_WIDTH)) u_mux_wdata (
        .in0_i      (m0_wdata),
        .in1_i      (m1_wdata),
        .choose_bit (sel_q),
        .out_o      (mem_wdata)
    );

    mux2 #(.WIDTH(1)) u_mux_we (
        .in0_i      (m0_we),
        .in1_i      (m1_we),
        .choose_bit (sel_q),
        .out_o      (w_we_steer)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sel    = sel_q;
    assign m0_gnt = m0_gnt_q;
    assign m1_gnt = m1_gnt_q;
    assign mem_en = (state_q != ST_IDLE);
    assign mem_we = mem_en & w_we_steer;

    // Read data is only forwarded on a successful completion so the bus is
    // quiet (zero) at all other times, including reset.
    assign rdata  = ((m0_done & ~m0_err) | (m1_done & ~m1_err)) ? mem_rdata : '0;

endmodule : mem_port_arbiter2
`default_nettype wire

// File: tb/tb_mem_port_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter2
// Purpose  : Self-checking bench for mem_port_arbiter2: directed scenarios
//            with literal expectations plus randomized traffic compared each
//            cycle against a transaction-level reference model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter2;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;

    logic          m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
    logic [DW-1:0] rdata;
    logic          sel, mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_done   (m0_done),
        .m0_err    (m0_err),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_done   (m1_done),
        .m1_err    (m1_err),
        .rdata     (rdata),
        .sel       (sel),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Reference model: who owns the port, how many BUSY cycles it has had,
    // and who was served last.  owner = -1 means the port is idle.
    // ------------------------------------------------------------------
    int m_owner = -1;
    int m_age   = 0;
    int m_last  = 1;
    int m_sel   = 0;
    bit e_done0 = 1'b0;
    bit e_done1 = 1'b0;

    function automatic int pick(input logic r0, input logic r1, input int last);
        if (r0 && r1) return 1 - last;
        if (r0)       return 0;
        if (r1)       return 1;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner <= -1;
            m_age   <= 0;
            m_last  <= 1;
            m_sel   <= 0;
        end else if (m_owner >= 0) begin
            if (mem_ready || (m_age == TO - 1)) m_owner <= -1;
            else                                m_age   <= m_age + 1;
        end else if (pick(m0_req, m1_req, m_last) >= 0) begin
            m_owner <= pick(m0_req, m1_req, m_last);
            m_last  <= pick(m0_req, m1_req, m_last);
            m_sel   <= pick(m0_req, m1_req, m_last);
            m_age   <= 0;
        end
    end

    // Compare process: every output, every cycle.
    always @(negedge clk) begin
        bit busy, done, err, wexp;
        busy = (m_owner >= 0);
        done = busy && (mem_ready || (m_age == TO - 1));
        err  = done && !mem_ready;
        wexp = (m_sel == 1) ? m1_we : m0_we;
        chk("cmp_m0_gnt",  m0_gnt,  busy && m_owner == 0 && m_age == 0);
        chk("cmp_m1_gnt",  m1_gnt,  busy && m_owner == 1 && m_age == 0);
        chk("cmp_m0_done", m0_done, done && m_owner == 0);
        chk("cmp_m1_done", m1_done, done && m_owner == 1);
        chk("cmp_m0_err",  m0_err,  err && m_owner == 0);
        chk("cmp_m1_err",  m1_err,  err && m_owner == 1);
        chk("cmp_rdata",   rdata,   (done && !err) ? mem_rdata : '0);
        chk("cmp_sel",     sel,     m_sel[0]);
        chk("cmp_mem_en",  mem_en,  busy);
        chk("cmp_mem_we",  mem_we,  busy && wexp);
        chk("cmp_mem_addr",  mem_addr,  (m_sel == 1) ? m1_addr  : m0_addr);
        chk("cmp_mem_wdata", mem_wdata, (m_sel == 1) ? m1_wdata : m0_wdata);
        e_done0 <= done && m_owner == 0;
        e_done1 <= done && m_owner == 1;
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int found;
        int gq[$];
        bit slow;

        // Reset state
        #2;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_sel",    sel,    0);
        chk("rst_gnt",    {m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err}, 0);
        cyc(); cyc();
        rst = 1'b0;
        cyc();

        // Simple M0 read, mem_ready on the 2nd BUSY cycle
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0040;
        cyc();
        #1;
        chk("t1_gnt",   m0_gnt,  1);
        chk("t1_done0", m0_done, 0);
        chk("t1_en",    mem_en,  1);
        cyc();
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("t1_done",  m0_done, 1);
        chk("t1_err",   m0_err,  0);
        chk("t1_rdata", rdata,   32'hDEAD_BEEF);
        cyc();
        m0_req = 1'b0; mem_ready = 1'b0;
        #1;
        chk("t1_idle",  mem_en,  0);

        // Continuous dual requests, immediate ready
        m0_req = 1'b1; m1_req = 1'b1; m1_addr = 32'h0000_2000;
        mem_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cyc();
            #1;
            if (m0_gnt) gq.push_back(0);
            if (m1_gnt) gq.push_back(1);
            if (m0_gnt || m1_gnt) chk("dual_sel", sel, gq[$]);
        end
        m0_req = 1'b0; m1_req = 1'b0; mem_ready = 1'b0;
        chk("dual_count", gq.size(), 6);
        if (gq.size() > 0) chk("dual_first", gq[0], 1);
        for (int i = 1; i < gq.size(); i++) chk("dual_alt", gq[i] != gq[i-1], 1);
        cyc(); cyc();

        // M1 write steering
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0000_1000; m1_wdata = 32'h1234_5678;
        m0_addr = 32'h0000_0ABC; m0_wdata = 32'h0BAD_0BAD;
        cyc();
        #1;
        chk("w_gnt",   m1_gnt,    1);
        chk("w_we",    mem_we,    1);
        chk("w_addr",  mem_addr,  32'h0000_1000);
        chk("w_wdata", mem_wdata, 32'h1234_5678);
        chk("w_m0",    {m0_gnt, m0_done, m0_err}, 0);
        cyc();
        mem_ready = 1'b1;
        #1;
        chk("w_done",  m1_done,   1);
        cyc();
        m1_req = 1'b0; m1_we = 1'b0; mem_ready = 1'b0;
        cyc();

        // Timeout with a pending M1
        m0_req = 1'b1;
        cyc();
        m1_req = 1'b1;
        found = 0;
        for (int k = 1; k <= TO + 4; k++) begin
            #1;
            if (m0_done) begin
                found = k;
                break;
            end
            cyc();
        end
        chk("to_cycle", found, TO);
        chk("to_err",   m0_err, 1);
        cyc();
        #1;
        chk("to_bubble", mem_en, 0);
        cyc();
        m0_req = 1'b0; mem_ready = 1'b1;
        #1;
        chk("to_m1_gnt",  m1_gnt,  1);
        chk("to_m1_done", m1_done, 1);
        cyc();
        m1_req = 1'b0; mem_ready = 1'b0;
        cyc();

        // mem_ready on the timeout cycle wins
        m0_req = 1'b1;
        cyc();
        for (int k = 1; k < TO; k++) cyc();
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
        #1;
        chk("tr_done",  m0_done, 1);
        chk("tr_err",   m0_err,  0);
        chk("tr_rdata", rdata,   32'hCAFE_F00D);
        cyc();
        m0_req = 1'b0; mem_ready = 1'b0;
        cyc();

        // Asynchronous reset in the middle of an M1 access
        m1_req = 1'b1;
        cyc();
        cyc();
        #2;
        rst = 1'b1;
        #1;
        chk("ar_en",   mem_en, 0);
        chk("ar_sel",  sel,    0);
        chk("ar_outs", {m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, mem_we}, 0);
        m0_req = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b0;
        cyc();
        mem_ready = 1'b1;
        #1;
        chk("ar_m0_first", m0_gnt, 1);
        chk("ar_m1_none",  m1_gnt, 0);
        cyc();
        m0_req = 1'b0; m1_req = 1'b0; mem_ready = 1'b0;
        cyc(); cyc(); cyc();

        // Randomized traffic against the model
        slow = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ((n % 64) == 0) slow = ($urandom_range(0, 1) == 1);
            if (m0_req && e_done0) begin
                if ($urandom_range(0, 1) == 1) m0_req = 1'b0;
                else begin
                    m0_we = $urandom_range(0, 1) == 1; m0_addr = $urandom; m0_wdata = $urandom;
                end
            end else if (!m0_req && $urandom_range(0, 2) == 0) begin
                m0_req = 1'b1; m0_we = $urandom_range(0, 1) == 1;
                m0_addr = $urandom; m0_wdata = $urandom;
            end
            if (m1_req && e_done1) begin
                if ($urandom_range(0, 1) == 1) m1_req = 1'b0;
                else begin
                    m1_we = $urandom_range(0, 1) == 1; m1_addr = $urandom; m1_wdata = $urandom;
                end
            end else if (!m1_req && $urandom_range(0, 2) == 0) begin
                m1_req = 1'b1; m1_we = $urandom_range(0, 1) == 1;
                m1_addr = $urandom; m1_wdata = $urandom;
            end
            mem_ready = slow ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 1) == 1);
            mem_rdata = $urandom;
            cyc();
        end
        m0_req = 1'b0; m1_req = 1'b0; mem_ready = 1'b1;
        cyc(); cyc(); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_port_arbiter2
`default_nettype wire
